// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 8;
  localparam int RF_N_RD   = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read, clear and status signals of the register file, grouped as one bus.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = $clog2(RF_DEPTH),
  parameter int N_RD   = RF_N_RD
);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;
  logic                     wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  rd_data, clr_busy, clr_done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output rd_data, clr_busy, clr_done, wr_err
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks entries 0..DEPTH-1 issuing one zero-write per cycle.
module regfile_clr_seq import regfile_pkg::*; #(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [0:0]        ST_IDLE  = RF_IDLE;
  localparam logic [0:0]        ST_CLEAR = RF_CLEAR;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_r;
  logic [0:0]        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;
  logic              done_r;
  logic              done_s;

  // Next-state: clr_req only matters in IDLE; CLEAR runs to the last entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_s = ST_CLEAR;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST) begin
          state_s = ST_IDLE;
          cnt_s   = {ADDR_W{1'b0}};
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  assign clr_busy = (state_r == ST_CLEAR);
  assign clr_we   = (state_r == ST_CLEAR);
  assign clr_addr = cnt_r;
  assign clr_done = done_r;

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, N_RD registered read ports, optional bypass
// and a hardware bulk-clear that takes priority over normal writes.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int N_RD   = RF_N_RD,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  rf
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0]      mem_r [DEPTH];
  logic [N_RD*DATA_W-1:0] rd_r;
  logic [N_RD*DATA_W-1:0] rd_s;
  logic                   err_r;
  logic                   err_s;
  logic                   wr_ok_s;
  logic                   clr_we_s;
  logic [ADDR_W-1:0]      clr_addr_s;
  logic                   clr_busy_s;
  logic                   clr_done_s;
  logic                   cm_we_s;
  logic [ADDR_W-1:0]      cm_addr_s;
  logic [DATA_W-1:0]      cm_data_s;

  // DEPTH need not be a power of two, so the top address codes are invalid.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  regfile_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (rf.clr_req),
    .clr_busy (clr_busy_s),
    .clr_done (clr_done_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Write arbitration: clear writes win; a clear start also blocks the user write.
  always_comb begin
    wr_ok_s = rf.wr_en && !clr_busy_s && !rf.clr_req && in_range(rf.wr_addr);
    err_s   = rf.wr_en && !wr_ok_s;
    if (clr_we_s) begin
      cm_we_s   = 1'b1;
      cm_addr_s = clr_addr_s;
      cm_data_s = {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      cm_we_s   = 1'b1;
      cm_addr_s = rf.wr_addr;
      cm_data_s = rf.wr_data;
    end else begin
      cm_we_s   = 1'b0;
      cm_addr_s = rf.wr_addr;
      cm_data_s = rf.wr_data;
    end
  end

  // Per-port read mux with optional forwarding of the write committed this edge.
  always_comb begin
    rd_s = {(N_RD*DATA_W){1'b0}};
    for (int k = 0; k < N_RD; k++) begin
      if (!in_range(rf.rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && cm_we_s && (cm_addr_s == rf.rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_s[k*DATA_W +: DATA_W] = cm_data_s;
      end else begin
        rd_s[k*DATA_W +: DATA_W] = mem_r[rf.rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (cm_we_s) begin
      mem_r[cm_addr_s] <= cm_data_s;
    end
  end

  // Registered read data and write-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r  <= {(N_RD*DATA_W){1'b0}};
      err_r <= 1'b0;
    end else begin
      rd_r  <= rd_s;
      err_r <= err_s;
    end
  end

  assign rf.rd_data  = rd_r;
  assign rf.clr_busy = clr_busy_s;
  assign rf.clr_done = clr_done_s;
  assign rf.wr_err   = err_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Two register files (8 deep with bypass, 6 deep without) driven in lockstep and
// compared each cycle against an array-based behavioural model.
module tb_regfile_mp;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       we    = 1'b0;
  logic [2:0] wa    = 3'd0;
  logic [7:0] wd    = 8'd0;
  logic [5:0] ra    = 6'd0;
  logic       cr    = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(8), .ADDR_W(3), .N_RD(2)) if0 ();
  regfile_mp_if #(.DATA_W(8), .ADDR_W(3), .N_RD(2)) if1 ();

  assign if0.wr_en = we;   assign if1.wr_en = we;
  assign if0.wr_addr = wa; assign if1.wr_addr = wa;
  assign if0.wr_data = wd; assign if1.wr_data = wd;
  assign if0.rd_addr = ra; assign if1.rd_addr = ra;
  assign if0.clr_req = cr; assign if1.clr_req = cr;

  regfile_mp #(.DATA_W(8), .DEPTH(8), .N_RD(2), .BYPASS(1)) u0 (.clk(clk), .rst_n(rst_n), .rf(if0));
  regfile_mp #(.DATA_W(8), .DEPTH(6), .N_RD(2), .BYPASS(0)) u1 (.clk(clk), .rst_n(rst_n), .rf(if1));

  wire [15:0] o_rd   [2];
  wire        o_busy [2];
  wire        o_done [2];
  wire        o_err  [2];
  assign o_rd[0] = if0.rd_data;    assign o_rd[1] = if1.rd_data;
  assign o_busy[0] = if0.clr_busy; assign o_busy[1] = if1.clr_busy;
  assign o_done[0] = if0.clr_done; assign o_done[1] = if1.clr_done;
  assign o_err[0] = if0.wr_err;    assign o_err[1] = if1.wr_err;

  // Reference model: contents, clear progress and expected outputs per instance.
  int         m_mem  [2][8];
  bit         m_busy [2];
  int         m_cnt  [2];
  logic [7:0] e_rd   [2][2];
  logic       e_busy [2];
  logic       e_done [2];
  logic       e_err  [2];

  function automatic int dep(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("d%0d_rd%0d", d, k), o_rd[d][k*8 +: 8], e_rd[d][k]);
      chk($sformatf("d%0d_busy", d), {7'd0, o_busy[d]}, {7'd0, e_busy[d]});
      chk($sformatf("d%0d_done", d), {7'd0, o_done[d]}, {7'd0, e_done[d]});
      chk($sformatf("d%0d_err", d),  {7'd0, o_err[d]},  {7'd0, e_err[d]});
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_mem[d][i] = 0;
      m_busy[d] = 1'b0;
      m_cnt[d]  = 0;
      e_rd[d][0] = 8'd0;
      e_rd[d][1] = 8'd0;
      e_busy[d] = 1'b0;
      e_done[d] = 1'b0;
      e_err[d]  = 1'b0;
    end
  endtask

  // Apply one clock edge worth of behaviour to the model, from the sampled inputs.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int  depth;
      bit  ok;
      depth = dep(d);
      ok = we && !m_busy[d] && !cr && (int'(wa) < depth);
      e_err[d] = we && !ok;
      for (int k = 0; k < 2; k++) begin
        int a;
        int v;
        a = int'(ra[k*3 +: 3]);
        if (a >= depth) v = 0;
        else if (d == 0 && m_busy[d] && a == m_cnt[d]) v = 0;
        else if (d == 0 && ok && a == int'(wa)) v = int'(wd);
        else v = m_mem[d][a];
        e_rd[d][k] = 8'(v);
      end
      e_done[d] = m_busy[d] && (m_cnt[d] == depth - 1);
      if (m_busy[d]) begin
        m_mem[d][m_cnt[d]] = 0;
        if (m_cnt[d] == depth - 1) begin
          m_busy[d] = 1'b0;
          m_cnt[d]  = 0;
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end else if (cr) begin
        m_busy[d] = 1'b1;
        m_cnt[d]  = 0;
      end
      if (ok) m_mem[d][wa] = int'(wd);
      e_busy[d] = m_busy[d];
    end
  endtask

  task automatic cyc(input logic i_we, input logic [2:0] i_wa, input logic [7:0] i_wd,
                     input logic [2:0] i_ra0, input logic [2:0] i_ra1, input logic i_cr);
    we = i_we; wa = i_wa; wd = i_wd; ra = {i_ra1, i_ra0}; cr = i_cr;
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic rst_assert();
    we = 1'b0; cr = 1'b0; ra = 6'd0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] base);
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), base + 8'(i), 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    #2;
    rst_assert();

    // Reset with every entry loaded, then read back zeros.
    load(8'h10);
    rst_assert();
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd3, 1'b0);
    chk("rst_rd0", o_rd[0][7:0], 8'h00);
    chk("rst_rd1", o_rd[0][15:8], 8'h00);
    chk("rst_busy", {7'd0, o_busy[0]}, 8'h00);
    chk("rst_err", {7'd0, o_err[0]}, 8'h00);

    // Write then read.
    cyc(1'b1, 3'd2, 8'hA5, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 8'd0, 3'd2, 3'd5, 1'b0);
    chk("wr_rd_a5", o_rd[0][7:0], 8'hA5);
    chk("wr_rd_other", o_rd[0][15:8], 8'h00);
    chk("wr_rd_a5_d6", o_rd[1][7:0], 8'hA5);

    // Same-edge write and read: forwarded on u0, old value on u1.
    cyc(1'b1, 3'd4, 8'h11, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 3'd4, 8'h3C, 3'd0, 3'd4, 1'b0);
    chk("bypass1", o_rd[0][15:8], 8'h3C);
    chk("bypass0", o_rd[1][15:8], 8'h11);
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd4, 1'b0);
    chk("after_bypass0", o_rd[1][15:8], 8'h3C);

    // Range check on the 6-deep instance.
    cyc(1'b1, 3'd6, 8'hFF, 3'd0, 3'd0, 1'b0);
    chk("range_err_d6", {7'd0, o_err[1]}, 8'h01);
    chk("range_ok_d8", {7'd0, o_err[0]}, 8'h00);
    cyc(1'b0, 3'd0, 8'd0, 3'd7, 3'd6, 1'b0);
    chk("range_err_pulse", {7'd0, o_err[1]}, 8'h00);
    chk("range_rd7_d6", o_rd[1][7:0], 8'h00);
    chk("range_rd6_d6", o_rd[1][15:8], 8'h00);
    chk("range_rd6_d8", o_rd[0][15:8], 8'hFF);

    // Bulk clear with a blocked write and a mid-sequence read.
    load(8'h10);
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
    chk("clr_start_busy", {7'd0, o_busy[0]}, 8'h01);
    for (int b = 1; b <= 8; b++) begin
      cyc(b == 1, 3'd1, 8'h77, 3'd1, (b == 3) ? 3'd7 : 3'd0, 1'b0);
      if (b == 1) chk("clr_wr_err", {7'd0, o_err[0]}, 8'h01);
      if (b == 3) chk("clr_rd7_mid", o_rd[0][15:8], 8'h17);
      chk($sformatf("clr_busy_%0d", b), {7'd0, o_busy[0]}, (b < 8) ? 8'h01 : 8'h00);
      chk($sformatf("clr_done_%0d", b), {7'd0, o_done[0]}, (b < 8) ? 8'h00 : 8'h01);
    end
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0);
    chk("clr_done_pulse", {7'd0, o_done[0]}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 3'd0, 8'd0, 3'(2*i), 3'(2*i+1), 1'b0);
      chk("clr_zero_a", o_rd[0][7:0], 8'h00);
      chk("clr_zero_b", o_rd[0][15:8], 8'h00);
    end

    // Reset mid-clear, then a fresh clear with a restart on the done edge.
    load(8'h20);
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
    for (int b = 1; b <= 3; b++) cyc(1'b0, 3'd0, 8'd0, 3'd7, 3'd5, 1'b0);
    rst_assert();
    chk("rstmid_busy", {7'd0, o_busy[0]}, 8'h00);
    chk("rstmid_done", {7'd0, o_done[0]}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 3'd0, 8'd0, 3'(2*i), 3'(2*i+1), 1'b0);
      chk("rstmid_zero_a", o_rd[0][7:0], 8'h00);
      chk("rstmid_zero_b", o_rd[0][15:8], 8'h00);
    end
    load(8'h30);
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
    chk("fresh_busy", {7'd0, o_busy[0]}, 8'h01);
    for (int b = 1; b <= 8; b++) cyc(1'b0, 3'd0, 8'd0, 3'd7, 3'd6, b == 3);
    chk("fresh_done", {7'd0, o_done[0]}, 8'h01);
    cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b1);
    chk("restart_busy", {7'd0, o_busy[0]}, 8'h01);
    for (int b = 1; b <= 8; b++) cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)),
          3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), $urandom_range(11, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
